gc_controller_poller: RTL

Upstream stage of the input viewer. It polls a GameCube controller over the single-wire open-drain bus and deserialises the 64-bit response. Results are presented as registered, frame-consistent button, stick and trigger values, which feed the viewer's display-composition block directly. It runs on the 25 MHz pixel clock.

---
 rtl/gc_pkg.sv | 24 ++
 rtl/gc_controller_poller_if.sv | 26 ++
 rtl/gc_bit_timer.sv | 17 +
 rtl/gc_controller_poller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// gc_pkg: FSM states, poll command, response field positions, decoded frame type and neutral values
package gc_pkg;
  typedef enum logic [2:0] {IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, CHECK, FAIL} gc_state_t;
  localparam logic [23:0] GC_POLL_CMD = 24'h400300;
  localparam logic [7:0] STICK_CENTRE = 8'd128;
  localparam logic [7:0] TRIG_REST = 8'd0;
  localparam int B0_MSB = 63, B1_MSB = 55, JOY_X_MSB = 47, JOY_Y_MSB = 39;
  localparam int C_X_MSB = 31, C_Y_MSB = 23, L_TRIG_MSB = 15, R_TRIG_MSB = 7;
  localparam int BIT_A = 0, BIT_B = 1, BIT_X = 2, BIT_Y = 3, BIT_START = 4;
  localparam int BIT_LEFT = 0, BIT_RIGHT = 1, BIT_DOWN = 2, BIT_UP = 3, BIT_Z = 4, BIT_R = 5, BIT_L = 6;
  typedef struct packed {
    logic [4:0] btn0;
    logic [6:0] btn1;
    logic [7:0] joy_x, joy_y, c_x, c_y, l_trig, r_trig;
  } gc_frame_t;
  localparam gc_frame_t NEUTRAL_FRAME = '{5'd0, 7'd0, STICK_CENTRE, STICK_CENTRE, STICK_CENTRE, STICK_CENTRE, TRIG_REST, TRIG_REST};
  function automatic logic frame_ok(input logic [63:0] r);
    return r[B0_MSB -: 3] == 3'b000 && r[B1_MSB];
  endfunction
  function automatic gc_frame_t decode(input logic [63:0] r);
    return '{r[B0_MSB-3 -: 5], r[B1_MSB-1 -: 7], r[JOY_X_MSB -: 8], r[JOY_Y_MSB -: 8],
             r[C_X_MSB -: 8], r[C_Y_MSB -: 8], r[L_TRIG_MSB -: 8], r[R_TRIG_MSB -: 8]};
  endfunction
endpackage

// File: rtl/gc_controller_poller_if.sv
// gc_controller_poller_if: open-drain bus (data_in/data_oe, rumble under GC_RUMBLE_EN) plus decoded frame outputs
interface gc_controller_poller_if;
  logic data_in, data_oe;
`ifdef GC_RUMBLE_EN
  logic rumble;
`endif
  logic A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT;
  logic [7:0] JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER;
  logic controller_present, frame_valid;
  modport master (
    input data_in,
`ifdef GC_RUMBLE_EN
    input rumble,
`endif
    output data_oe, A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
    output JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER, controller_present, frame_valid
  );
  modport slave (
    output data_in,
`ifdef GC_RUMBLE_EN
    output rumble,
`endif
    input data_oe, A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
    input JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER, controller_present, frame_valid
  );
endinterface

// File: rtl/gc_bit_timer.sv
// gc_bit_timer: down-counter loaded with us*CYCLES_PER_US on clk (sync reset), done pulses in the last cycle of the interval
module gc_bit_timer #(
  parameter int CYCLES_PER_US = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] us,
  output logic       done
);
  localparam int W = $clog2(3 * CYCLES_PER_US + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else cnt <= load ? W'(32'(us) * CYCLES_PER_US) : (cnt == '0 ? cnt : cnt - 1'b1);
  assign done = cnt == W'(1);
endmodule

// File: rtl/gc_controller_poller.sv
// gc_controller_poller: polls a GameCube pad (clk, sync reset; bus = data_in/data_oe + registered frame outputs; GC_RUMBLE_EN adds bus.rumble)
module gc_controller_poller
  import gc_pkg::*;
#(
  parameter int CYCLES_PER_US = 25,
  parameter int POLL_PERIOD = 416667,
  parameter int TIMEOUT_US = 100
) (
  input logic clk,
  input logic reset,
  gc_controller_poller_if.master bus
);
  localparam int TO_CYC = TIMEOUT_US * CYCLES_PER_US;
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int OW = $clog2(TO_CYC + 1);
  gc_state_t state, nxt;
  logic q1, q2, fall, oe, fv, present, cur_bit, nxt_bit, rum, tm_load, tm_done, last_poll, timeout;
  logic [1:0] tm_us;
  logic [4:0] idx, nxt_idx;
  logic [6:0] bit_cnt;
  logic [PW-1:0] poll_cnt;
  logic [OW-1:0] to_cnt;
  logic [63:0] sr;
  gc_frame_t frame_q;
`ifdef GC_RUMBLE_EN
  assign rum = bus.rumble;
`else
  assign rum = 1'b0;
`endif
  assign fall = !q1 && q2;
  assign last_poll = poll_cnt == PW'(POLL_PERIOD - 1);
  assign timeout = to_cnt == OW'(TO_CYC - 1);
  assign nxt_idx = state == IDLE ? 5'd0 : idx + 5'd1;
  assign nxt_bit = nxt_idx == 5'd23 ? rum : GC_POLL_CMD[5'd23 - nxt_idx];
  gc_bit_timer #(.CYCLES_PER_US(CYCLES_PER_US)) u_timer (
    .clk(clk), .reset(reset), .load(tm_load), .us(tm_us), .done(tm_done)
  );
  always_comb begin
    nxt = state;
    tm_load = 1'b0;
    tm_us = 2'd1;
    case (state)
      IDLE: if (last_poll) begin
        nxt = TX_LOW;
        tm_load = 1'b1;
        tm_us = nxt_bit ? 2'd1 : 2'd3;
      end
      TX_LOW: if (tm_done) begin
        nxt = TX_HIGH;
        tm_load = 1'b1;
        tm_us = cur_bit ? 2'd3 : 2'd1;
      end
      TX_HIGH: if (tm_done) begin
        nxt = idx == 5'd23 ? TX_STOP : TX_LOW;
        tm_load = 1'b1;
        tm_us = idx == 5'd23 || nxt_bit ? 2'd1 : 2'd3;
      end
      TX_STOP: if (tm_done) nxt = RX_WAIT_FALL;
      RX_WAIT_FALL: if (fall) begin
        nxt = RX_SAMPLE;
        tm_load = 1'b1;
        tm_us = 2'd2;
      end else if (timeout) nxt = FAIL;
      RX_SAMPLE: if (tm_done) nxt = bit_cnt == 7'd63 ? CHECK : RX_WAIT_FALL;
      CHECK: nxt = frame_ok(sr) ? IDLE : FAIL;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      {q1, q2} <= 2'b11;
      oe <= 1'b0;
      fv <= 1'b0;
      present <= 1'b0;
      cur_bit <= 1'b0;
      idx <= '0;
      bit_cnt <= '0;
      poll_cnt <= '0;
      to_cnt <= '0;
      sr <= '0;
      frame_q <= NEUTRAL_FRAME;
    end else begin
      state <= nxt;
      q1 <= bus.data_in;
      q2 <= q1;
      oe <= nxt == TX_LOW || nxt == TX_STOP;
      poll_cnt <= state == IDLE && !last_poll ? poll_cnt + 1'b1 : '0;
      to_cnt <= state == RX_WAIT_FALL && !fall ? to_cnt + 1'b1 : '0;
      fv <= state == CHECK && frame_ok(sr);
      // The bit value is latched when its low phase starts so the high phase (and rumble) stays consistent.
      if (nxt == TX_LOW && tm_load) begin
        idx <= nxt_idx;
        cur_bit <= nxt_bit;
      end
      if (state == TX_STOP) bit_cnt <= '0;
      else if (state == RX_SAMPLE && tm_done) begin
        sr <= {sr[62:0], q2};
        bit_cnt <= bit_cnt + 7'd1;
      end
      if (state == CHECK && frame_ok(sr)) begin
        frame_q <= decode(sr);
        present <= 1'b1;
      end else if (state == FAIL) begin
        frame_q <= NEUTRAL_FRAME;
        present <= 1'b0;
      end
    end
  assign bus.data_oe = oe;
  assign bus.frame_valid = fv;
  assign bus.controller_present = present;
  assign bus.A = frame_q.btn0[BIT_A];
  assign bus.B = frame_q.btn0[BIT_B];
  assign bus.X = frame_q.btn0[BIT_X];
  assign bus.Y = frame_q.btn0[BIT_Y];
  assign bus.start_pause = frame_q.btn0[BIT_START];
  assign bus.L = frame_q.btn1[BIT_L];
  assign bus.R = frame_q.btn1[BIT_R];
  assign bus.Z = frame_q.btn1[BIT_Z];
  assign bus.D_UP = frame_q.btn1[BIT_UP];
  assign bus.D_DOWN = frame_q.btn1[BIT_DOWN];
  assign bus.D_RIGHT = frame_q.btn1[BIT_RIGHT];
  assign bus.D_LEFT = frame_q.btn1[BIT_LEFT];
  assign bus.JOY_X = frame_q.joy_x;
  assign bus.JOY_Y = frame_q.joy_y;
  assign bus.C_STICK_X = frame_q.c_x;
  assign bus.C_STICK_Y = frame_q.c_y;
  assign bus.L_TRIGGER = frame_q.l_trig;
  assign bus.R_TRIGGER = frame_q.r_trig;
endmodule
